// File: rtl/rx_ber_checker.sv
// rx_ber_checker: PRBS9 bit-error-rate checker for an oversampled I/Q stream.
// A symbol strobe is picked out of every OS samples. Each branch slices the
// sample sign, predicts it from its own decision history (x^9+x^5+1), and runs
// a FILL/CHECK/LOCK qualifier. Symbols and errors are counted only while locked.
module rx_ber_checker #(
  parameter int OS        = 4,
  parameter int NB_SAMPLE = 4,
  parameter int WIN       = 64,
  parameter int THR       = 8
) (
  input  logic                  clock,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [$clog2(OS)-1:0] i_phase,
  input  logic                  i_clear,
  input  logic [NB_SAMPLE-1:0]  i_sampleI,
  input  logic [NB_SAMPLE-1:0]  i_sampleQ,
  output logic                  o_sym_valid,
  output logic                  o_lockI,
  output logic                  o_lockQ,
  output logic [31:0]           o_bitsI,
  output logic [31:0]           o_bitsQ,
  output logic [31:0]           o_errI,
  output logic [31:0]           o_errQ
);

  localparam int PW = $clog2(OS);
  localparam int WW = $clog2(WIN);
  localparam int EW = $clog2(WIN + 1);

  typedef enum logic [1:0] {FILL, CHECK, LOCK} stateT;

  logic [PW-1:0] phaseCnt;
  logic          strobe;
  logic          symValidReg;
  logic          decArr  [2];
  logic          lockArr [2];
  logic [31:0]   bitsArr [2];
  logic [31:0]   errArr  [2];

  // Only the sign bit carries the decision; the magnitude bits are ignored.
  logic unusedBits;
  assign unusedBits = ^{i_sampleI[NB_SAMPLE-2:0], i_sampleQ[NB_SAMPLE-2:0]};

  assign decArr[0] = i_sampleI[NB_SAMPLE-1];
  assign decArr[1] = i_sampleQ[NB_SAMPLE-1];

  // A new i_phase only moves the strobe; the counter itself never re-aligns.
  assign strobe = i_enable && (phaseCnt == i_phase);

  // Free-running sample phase counter, advancing only on valid samples.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      phaseCnt <= '0;
    end else if (i_enable) begin
      phaseCnt <= (phaseCnt == PW'(OS - 1)) ? '0 : phaseCnt + 1'b1;
    end
  end

  // Registered symbol-valid pulse, one cycle after the strobe.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      symValidReg <= 1'b0;
    end else begin
      symValidReg <= strobe;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : gBranch
    stateT         stateReg;
    logic [8:0]    histReg;
    logic [3:0]    fillCnt;
    logic [WW-1:0] symCnt;
    logic [EW-1:0] winErr;
    logic          seenOne;
    logic          lockReg;
    logic [31:0]   bitsReg;
    logic [31:0]   errReg;

    logic          predBit;
    logic          symErr;
    logic [EW-1:0] winErrNext;
    logic          seenNext;
    logic          winEnd;
    logic          winPass;

    // histReg[0] is the previous decision, histReg[8] the one 9 symbols back.
    assign predBit    = histReg[8] ^ histReg[4];
    assign symErr     = decArr[gi] ^ predBit;
    assign winErrNext = (symErr && (winErr != EW'(WIN))) ? winErr + 1'b1 : winErr;
    assign seenNext   = seenOne | decArr[gi];
    assign winEnd     = (symCnt == WW'(WIN - 1));
    // An all-zero window is a dead channel, not a clean one, so it never passes.
    assign winPass    = (winErrNext <= EW'(THR)) && seenNext;

    // Decision history and FILL/CHECK/LOCK qualifier, advanced once per symbol.
    always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
        stateReg <= FILL;
        histReg  <= '0;
        fillCnt  <= '0;
        symCnt   <= '0;
        winErr   <= '0;
        seenOne  <= 1'b0;
        lockReg  <= 1'b0;
      end else if (strobe) begin
        histReg <= {histReg[7:0], decArr[gi]};
        case (stateReg)
          FILL: begin
            if (fillCnt == 4'd8) begin
              stateReg <= CHECK;
              fillCnt  <= '0;
              symCnt   <= '0;
              winErr   <= '0;
              seenOne  <= 1'b0;
            end else begin
              fillCnt <= fillCnt + 1'b1;
            end
          end
          CHECK, LOCK: begin
            if (winEnd) begin
              symCnt  <= '0;
              winErr  <= '0;
              seenOne <= 1'b0;
              if (winPass) begin
                stateReg <= LOCK;
                lockReg  <= 1'b1;
              end else begin
                stateReg <= FILL;
                lockReg  <= 1'b0;
                fillCnt  <= '0;
              end
            end else begin
              symCnt  <= symCnt + 1'b1;
              winErr  <= winErrNext;
              seenOne <= seenNext;
            end
          end
          default: begin
            stateReg <= FILL;
            lockReg  <= 1'b0;
            fillCnt  <= '0;
          end
        endcase
      end
    end

    // Saturating bit/error counters; a clear beats any same-cycle increment.
    always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
        bitsReg <= '0;
        errReg  <= '0;
      end else if (i_clear) begin
        bitsReg <= '0;
        errReg  <= '0;
      end else if (strobe && (stateReg == LOCK)) begin
        if (bitsReg != '1) begin
          bitsReg <= bitsReg + 1'b1;
        end
        if (symErr && (errReg != '1)) begin
          errReg <= errReg + 1'b1;
        end
      end
    end

    assign lockArr[gi] = lockReg;
    assign bitsArr[gi] = bitsReg;
    assign errArr[gi]  = errReg;
  end

  assign o_sym_valid = symValidReg;
  assign o_lockI     = lockArr[0];
  assign o_lockQ     = lockArr[1];
  assign o_bitsI     = bitsArr[0];
  assign o_bitsQ     = bitsArr[1];
  assign o_errI      = errArr[0];
  assign o_errQ      = errArr[1];

endmodule

// File: tb/tb_rx_ber_checker.sv
// Bench for rx_ber_checker: PRBS9 symbols, +1/-1 mapped and zero-stuffed,
// with expected per-symbol outputs queued at drive time and compared on
// every o_sym_valid pulse.
module tb_rx_ber_checker;

  localparam int OS  = 4;
  localparam int NB  = 4;
  localparam int WIN = 64;
  localparam int THR = 8;

  logic          clock = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic [1:0]    i_phase;
  logic          i_clear;
  logic [NB-1:0] i_sampleI;
  logic [NB-1:0] i_sampleQ;
  logic          o_sym_valid;
  logic          o_lockI, o_lockQ;
  logic [31:0]   o_bitsI, o_bitsQ, o_errI, o_errQ;

  rx_ber_checker #(.OS(OS), .NB_SAMPLE(NB), .WIN(WIN), .THR(THR)) dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_phase     (i_phase),
    .i_clear     (i_clear),
    .i_sampleI   (i_sampleI),
    .i_sampleQ   (i_sampleQ),
    .o_sym_valid (o_sym_valid),
    .o_lockI     (o_lockI),
    .o_lockQ     (o_lockQ),
    .o_bitsI     (o_bitsI),
    .o_bitsQ     (o_bitsQ),
    .o_errI      (o_errI),
    .o_errQ      (o_errQ)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          sym;
    bit          chkLockI;
    bit          chkCntI;
    bit          lockI;
    bit          lockQ;
    logic [31:0] bitsI;
    logic [31:0] errI;
    logic [31:0] bitsQ;
    logic [31:0] errQ;
  } expT;

  expT         expQueue [$];
  int          errAt [$];
  int          errors = 0;
  int          checks = 0;

  // Reference model state
  int          symN;
  int          lockAtI, lockAtQ;
  bit          iKnown, iLockKnown;
  logic [31:0] expBitsI, expErrI, expBitsQ, expErrQ;
  bit   [8:0]  genI = 9'h1FF;
  bit   [8:0]  genQ = 9'h0A5;

  task automatic modelReset();
    symN       = 0;
    lockAtI    = 73;
    lockAtQ    = 73;
    iKnown     = 1'b1;
    iLockKnown = 1'b1;
    expBitsI   = '0;
    expErrI    = '0;
    expBitsQ   = '0;
    expErrQ    = '0;
    errAt.delete();
    expQueue.delete();
  endtask

  task automatic doReset();
    i_reset  = 1'b0;
    i_enable = 1'b0;
    i_clear  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    i_reset = 1'b1;
    modelReset();
  endtask

  // One symbol: OS samples, symbol value on sample 0, zeros elsewhere.
  task automatic sendSym(input bit clr, input bit flipI, input bit randI);
    bit  bI, bQ, dI, errNow;
    expT e;
    symN++;
    bI   = genI[8] ^ genI[4];
    genI = {genI[7:0], bI};
    bQ   = genQ[8] ^ genQ[4];
    genQ = {genQ[7:0], bQ};
    dI   = randI ? bit'($urandom_range(0, 1)) : (bI ^ flipI);
    if (flipI) begin
      errAt.push_back(symN);
      errAt.push_back(symN + 5);
      errAt.push_back(symN + 9);
    end
    errNow = 1'b0;
    for (int k = errAt.size() - 1; k >= 0; k--) begin
      if (errAt[k] == symN) begin
        errNow = 1'b1;
        errAt.delete(k);
      end
    end
    if (clr) begin
      expBitsQ = '0;
      expErrQ  = '0;
    end else if (symN > lockAtQ) begin
      expBitsQ = expBitsQ + 1;
    end
    if (clr) begin
      expBitsI = '0;
      expErrI  = '0;
      iKnown   = 1'b1;
    end else if (symN > lockAtI) begin
      expBitsI = expBitsI + 1;
      if (errNow) expErrI = expErrI + 1;
    end
    e.sym      = symN;
    e.chkLockI = iLockKnown;
    e.chkCntI  = iKnown;
    e.lockI    = (symN >= lockAtI);
    e.lockQ    = (symN >= lockAtQ);
    e.bitsI    = expBitsI;
    e.errI     = expErrI;
    e.bitsQ    = expBitsQ;
    e.errQ     = expErrQ;
    expQueue.push_back(e);
    for (int k = 0; k < OS; k++) begin
      i_enable  = 1'b1;
      i_clear   = clr && (k == 0);
      i_sampleI = (k == 0) ? (dI ? 4'hF : 4'h1) : 4'h0;
      i_sampleQ = (k == 0) ? (bQ ? 4'hF : 4'h1) : 4'h0;
      @(posedge clock);
      #1;
    end
    i_enable  = 1'b0;
    i_clear   = 1'b0;
    i_sampleI = '0;
    i_sampleQ = '0;
  endtask

  // Scoreboard: pop one expectation per symbol-valid pulse.
  expT monE;
  always @(negedge clock) begin
    if (i_reset && o_sym_valid) begin
      if (expQueue.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sym_valid: got unexpected pulse, expected none");
      end else begin
        monE = expQueue.pop_front();
        $display("sym %0d: lockI=%0b lockQ=%0b bitsI=%0d errI=%0d bitsQ=%0d errQ=%0d",
                 monE.sym, o_lockI, o_lockQ, o_bitsI, o_errI, o_bitsQ, o_errQ);
        checks++;
        if (o_lockQ !== monE.lockQ) begin
          errors++;
          $display("FAIL lockQ sym %0d: got %0b expected %0b", monE.sym, o_lockQ, monE.lockQ);
        end
        checks++;
        if (o_bitsQ !== monE.bitsQ) begin
          errors++;
          $display("FAIL bitsQ sym %0d: got %0d expected %0d", monE.sym, o_bitsQ, monE.bitsQ);
        end
        checks++;
        if (o_errQ !== monE.errQ) begin
          errors++;
          $display("FAIL errQ sym %0d: got %0d expected %0d", monE.sym, o_errQ, monE.errQ);
        end
        if (monE.chkLockI) begin
          checks++;
          if (o_lockI !== monE.lockI) begin
            errors++;
            $display("FAIL lockI sym %0d: got %0b expected %0b", monE.sym, o_lockI, monE.lockI);
          end
        end
        if (monE.chkCntI) begin
          checks++;
          if (o_bitsI !== monE.bitsI) begin
            errors++;
            $display("FAIL bitsI sym %0d: got %0d expected %0d", monE.sym, o_bitsI, monE.bitsI);
          end
          checks++;
          if (o_errI !== monE.errI) begin
            errors++;
            $display("FAIL errI sym %0d: got %0d expected %0d", monE.sym, o_errI, monE.errI);
          end
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    logic [199:0] outs;
    outs = {o_sym_valid, o_lockI, o_lockQ, o_bitsI, o_bitsQ, o_errI, o_errQ, 37'd0};
    checks++;
    if (outs !== 200'd0) begin
      errors++;
      $display("FAIL %s: got valid=%0b lockI=%0b lockQ=%0b bitsI=%0d bitsQ=%0d errI=%0d errQ=%0d expected all 0",
               tag, o_sym_valid, o_lockI, o_lockQ, o_bitsI, o_bitsQ, o_errI, o_errQ);
    end
  endtask

  task automatic test_reset();
    i_reset   = 1'b0;
    i_enable  = 1'b0;
    i_clear   = 1'b0;
    i_phase   = 2'd0;
    i_sampleI = '0;
    i_sampleQ = '0;
    modelReset();
    repeat (3) @(posedge clock);
    #1;
    checkAllZero("reset_state");
    i_reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (o_sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: got %0b expected 0", o_sym_valid);
    end
  endtask

  // Strobe on the zero-stuffed phase: decisions all 0, lock must never come.
  task automatic test_phase_off();
    doReset();
    i_phase = 2'd1;
    lockAtI = 1 << 30;
    lockAtQ = 1 << 30;
    for (int n = 0; n < 80; n++) sendSym(1'b0, 1'b0, 1'b0);
    i_phase = 2'd0;
  endtask

  task automatic test_lock();
    doReset();
    for (int n = 0; n < 100; n++) sendSym(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_flip();
    for (int n = 0; n < 20; n++) sendSym(1'b0, (n == 3), 1'b0);
    checks++;
    if (o_lockI !== 1'b1) begin
      errors++;
      $display("FAIL flip_lock: got %0b expected 1", o_lockI);
    end
  endtask

  // Random I starting at window position 10: the first boundary comes after 55
  // random symbols, and the failed CHECK window ends exactly as clean data returns.
  task automatic test_random();
    while (((symN - 73) % WIN) != 9) sendSym(1'b0, 1'b0, 1'b0);
    iKnown     = 1'b0;
    iLockKnown = 1'b0;
    lockAtI    = 1 << 30;
    for (int n = 1; n <= 2 * WIN; n++) begin
      sendSym(1'b0, 1'b0, 1'b1);
      if (n == 54) begin
        checks++;
        if (o_lockI !== 1'b1) begin
          errors++;
          $display("FAIL rand_hold_lock: got %0b expected 1", o_lockI);
        end
      end
      if (n == 55) begin
        checks++;
        if (o_lockI !== 1'b0) begin
          errors++;
          $display("FAIL rand_drop_lock: got %0b expected 0", o_lockI);
        end
      end
    end
    iLockKnown = 1'b1;
    lockAtI    = symN + 9 + WIN;
    for (int n = 0; n < 80; n++) sendSym(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    sendSym(1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 20; n++) sendSym(1'b0, 1'b0, 1'b0);
    checks++;
    if (o_errI !== 32'd2) begin
      errors++;
      $display("FAIL clear_errI_after: got %0d expected 2", o_errI);
    end
  endtask

  task automatic test_reset_midlock();
    checks++;
    if ({o_lockI, o_lockQ} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset_lock: got %0b%0b expected 11", o_lockI, o_lockQ);
    end
    #2;
    i_reset = 1'b0;
    #1;
    checkAllZero("async_reset");
    doReset();
    for (int n = 0; n < 80; n++) sendSym(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_phase_off();
    test_lock();
    test_flip();
    test_random();
    test_clear();
    test_reset_midlock();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (expQueue.size() != 0) begin
      errors++;
      $display("FAIL pending_symbols: got %0d outstanding expected 0", expQueue.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
